// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared helpers and per-stage tag type for dff_pipe.
// Parity tag storage exists only when DFF_PIPE_PARITY_EN is defined.
package dff_pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Data width is set per instance, so the data word travels beside this tag.
    typedef struct packed {
        logic valid;
`ifdef DFF_PIPE_PARITY_EN
        logic parity;
`endif
    } stage_tag_t;

    localparam int TAG_W = $bits(stage_tag_t);

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one data+tag register with async reset, sync clear and enable.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [TAG_W-1:0] TAG_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic [TAG_W-1:0] tag_d,
    output logic [WIDTH-1:0] q,
    output logic [TAG_W-1:0] tag_q
);

    always_ff @(posedge clk or posedge reset)
        if (reset) {q, tag_q} <= {RESET_VAL, TAG_RST};
        else if (clr) {q, tag_q} <= {RESET_VAL, TAG_RST};
        else if (en) {q, tag_q} <= {d, tag_d};

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage stallable delay line with valid tracking and occupancy count.
// Define DFF_PIPE_PARITY_EN to add per-stage parity with par_inj / par_err.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           d,
    input  logic                       vld_in,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
    output logic                       vld_out,
    output logic [cnt_w(DEPTH)-1:0]    count
`ifdef DFF_PIPE_PARITY_EN
    ,
    input  logic                       par_inj,
    output logic                       par_err
`endif
);

    localparam int CW = cnt_w(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
    localparam stage_tag_t TAG_RST = '{valid: 1'b0, parity: ^RESET_VAL};
`else
    localparam stage_tag_t TAG_RST = '{valid: 1'b0};
`endif

    logic [WIDTH-1:0] data [DEPTH+1];
    stage_tag_t       tag  [DEPTH+1];

    assign data[0] = d;
`ifdef DFF_PIPE_PARITY_EN
    assign tag[0] = '{valid: vld_in, parity: ^d ^ par_inj};
`else
    assign tag[0] = '{valid: vld_in};
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH(WIDTH),
            .RESET_VAL(RESET_VAL),
            .TAG_RST(TAG_RST)
        ) u_stage (
            .clk(clk),
            .reset(reset),
            .en(en),
            .clr(clr),
            .d(data[i]),
            .tag_d(tag[i]),
            .q(data[i+1]),
            .tag_q(tag[i+1])
        );
    end

    assign q       = data[DEPTH];
    assign qb      = ~q;
    assign vld_out = tag[DEPTH].valid;
`ifdef DFF_PIPE_PARITY_EN
    assign par_err = vld_out & (^q != tag[DEPTH].parity);
`endif

    // Entering and leaving items cancel, so count stays within 0..DEPTH.
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + CW'(vld_in) - CW'(vld_out);

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe (8x3 instance) plus a 1x1 flop-equivalent instance.
// Parity scenario is compiled only when DFF_PIPE_PARITY_EN is defined.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, clr = 1'b0, vld_in = 1'b0;
    logic [7:0] d = '0, q, qb;
    logic       vld_out;
    logic [1:0] count;
`ifdef DFF_PIPE_PARITY_EN
    logic       par_inj = 1'b0, par_err;
`endif

    logic d1 = 1'b0, q1, qb1, vld_out1, count1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .clr(clr),
        .d(d),
        .vld_in(vld_in),
        .q(q),
        .qb(qb),
        .vld_out(vld_out),
        .count(count)
`ifdef DFF_PIPE_PARITY_EN
        ,
        .par_inj(par_inj),
        .par_err(par_err)
`endif
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u1 (
        .clk(clk),
        .reset(reset),
        .en(1'b1),
        .clr(1'b0),
        .d(d1),
        .vld_in(1'b1),
        .q(q1),
        .qb(qb1),
        .vld_out(vld_out1),
        .count(count1)
`ifdef DFF_PIPE_PARITY_EN
        ,
        .par_inj(1'b0),
        .par_err()
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every valid item leaving the pipe must match the oldest expected entry.
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] nq;
        if (!reset) begin
            nq = ~q;
            chk("qb_is_not_q", qb, nq);
            if (vld_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_unexpected: got %h expected none", q);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", q, e);
                end
            end
        end
    end

    initial begin
        logic b, nb;
        #12;
        chk("rst_q", q, 8'h00);
        chk("rst_qb", qb, 8'hFF);
        chk("rst_vld", {7'd0, vld_out}, 8'd0);
        chk("rst_cnt", {6'd0, count}, 8'd0);
        chk("rst_q1", {7'd0, q1}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // single item, latency 3
        en = 1'b1; vld_in = 1'b1; d = 8'hA5; sb.push_back(8'hA5);
        cyc; chk("s1_cnt1", {6'd0, count}, 8'd1); chk("s1_vo1", {7'd0, vld_out}, 8'd0);
        vld_in = 1'b0; d = 8'h00;
        cyc; chk("s1_cnt2", {6'd0, count}, 8'd1); chk("s1_vo2", {7'd0, vld_out}, 8'd0);
        cyc; chk("s1_vo3", {7'd0, vld_out}, 8'd1); chk("s1_q3", q, 8'hA5);
        chk("s1_qb3", qb, 8'h5A); chk("s1_cnt3", {6'd0, count}, 8'd1);
        cyc; chk("s1_vo4", {7'd0, vld_out}, 8'd0); chk("s1_cnt4", {6'd0, count}, 8'd0);

        // stream 1..4 with a 2-cycle stall after item 2
        vld_in = 1'b1; d = 8'd1; sb.push_back(8'd1);
        cyc; chk("s2_cnt_a", {6'd0, count}, 8'd1);
        d = 8'd2; sb.push_back(8'd2);
        cyc; chk("s2_cnt_b", {6'd0, count}, 8'd2);
        en = 1'b0; vld_in = 1'b0; d = 8'hEE;
        cyc; chk("s2_stall1_cnt", {6'd0, count}, 8'd2); chk("s2_stall1_vo", {7'd0, vld_out}, 8'd0);
        cyc; chk("s2_stall2_cnt", {6'd0, count}, 8'd2); chk("s2_stall2_vo", {7'd0, vld_out}, 8'd0);
        en = 1'b1; vld_in = 1'b1; d = 8'd3; sb.push_back(8'd3);
        cyc; chk("s2_cnt_e", {6'd0, count}, 8'd3); chk("s2_vo_e", {7'd0, vld_out}, 8'd1); chk("s2_q_e", q, 8'd1);
        d = 8'd4; sb.push_back(8'd4);
        cyc; chk("s2_cnt_f", {6'd0, count}, 8'd3); chk("s2_q_f", q, 8'd2);
        vld_in = 1'b0; d = 8'h00;
        cyc; chk("s2_cnt_g", {6'd0, count}, 8'd2); chk("s2_q_g", q, 8'd3);
        cyc; chk("s2_cnt_h", {6'd0, count}, 8'd1); chk("s2_q_h", q, 8'd4);
        cyc; chk("s2_cnt_i", {6'd0, count}, 8'd0); chk("s2_vo_i", {7'd0, vld_out}, 8'd0);

        // fill, then clear with en high
        vld_in = 1'b1;
        d = 8'h10; sb.push_back(8'h10); cyc;
        d = 8'h20; sb.push_back(8'h20); cyc;
        d = 8'h30; sb.push_back(8'h30); cyc;
        chk("s3_full_cnt", {6'd0, count}, 8'd3); chk("s3_full_q", q, 8'h10);
        clr = 1'b1; d = 8'h40;
        cyc; sb.delete();
        chk("s3_clr_vo", {7'd0, vld_out}, 8'd0); chk("s3_clr_cnt", {6'd0, count}, 8'd0);
        chk("s3_clr_q", q, 8'h00); chk("s3_clr_qb", qb, 8'hFF);
        // clear also wins while stalled
        clr = 1'b0; d = 8'h55; sb.push_back(8'h55);
        cyc; chk("s3_one_cnt", {6'd0, count}, 8'd1);
        en = 1'b0; clr = 1'b1; vld_in = 1'b0;
        cyc; sb.delete(); chk("s3_clr_noen_cnt", {6'd0, count}, 8'd0);
        clr = 1'b0; en = 1'b1;
        cyc; cyc; cyc; chk("s3_after_clr_vo", {7'd0, vld_out}, 8'd0);

        // async reset mid-stream
        vld_in = 1'b1;
        d = 8'h77; sb.push_back(8'h77); cyc;
        d = 8'h88; sb.push_back(8'h88); cyc;
        chk("s4_pre_cnt", {6'd0, count}, 8'd2);
        reset = 1'b1; vld_in = 1'b0; d = 8'h00;
        #1;
        sb.delete();
        chk("s4_q", q, 8'h00); chk("s4_qb", qb, 8'hFF);
        chk("s4_vo", {7'd0, vld_out}, 8'd0); chk("s4_cnt", {6'd0, count}, 8'd0);
        cyc;
        reset = 1'b0;
        vld_in = 1'b1; d = 8'h99; sb.push_back(8'h99);
        cyc; vld_in = 1'b0; d = 8'h00;
        cyc; cyc; chk("s4_post_q", q, 8'h99); chk("s4_post_vo", {7'd0, vld_out}, 8'd1);
        cyc;

`ifdef DFF_PIPE_PARITY_EN
        // corrupted parity followed by a clean item with the same data
        par_inj = 1'b1; vld_in = 1'b1; d = 8'h0F; sb.push_back(8'h0F);
        cyc; par_inj = 1'b0; sb.push_back(8'h0F);
        cyc; vld_in = 1'b0; d = 8'h00;
        chk("par_idle", {7'd0, par_err}, 8'd0);
        cyc; chk("par_bad", {7'd0, par_err}, 8'd1); chk("par_bad_vo", {7'd0, vld_out}, 8'd1);
        cyc; chk("par_clean", {7'd0, par_err}, 8'd0); chk("par_clean_vo", {7'd0, vld_out}, 8'd1);
        cyc; chk("par_drain", {7'd0, par_err}, 8'd0);
`endif

        // DEPTH=1, WIDTH=1 behaves as a plain D flop
        for (int i = 0; i < 12; i++) begin
            b = 1'($urandom);
            nb = ~b;
            d1 = b;
            cyc;
            chk("flop_q", {7'd0, q1}, {7'd0, b});
            chk("flop_qb", {7'd0, qb1}, {7'd0, nb});
        end
        chk("flop_vo", {7'd0, vld_out1}, 8'd1);

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
